// File: rtl/pio_arb_pkg.sv
// rtl/pio_arb_pkg.sv - shared types and constants for the PIO output arbiter
package pio_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam int HOLD_W = 16;

    // Index width for a requester count; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pio_out_arbiter_if.sv
// rtl/pio_out_arbiter_if.sv - requester-side write/grant bundle of the PIO output arbiter
interface pio_out_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) ();

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] wdata;
    logic [NUM_REQ*WIDTH-1:0] wmask;
    logic [NUM_REQ-1:0]       gnt;

    modport master (
        output req,
        output wdata,
        output wmask,
        input  gnt
    );

    modport slave (
        input  req,
        input  wdata,
        input  wmask,
        output gnt
    );

endinterface

// File: rtl/pio_out_arbiter_rr_pick.sv
// rtl/pio_out_arbiter_rr_pick.sv - combinational round-robin selector starting after the last winner
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               any,
    output logic [IDX_W-1:0]   sel
);

    int idx;

    // Walk from the farthest candidate back to last+1 so the nearest set bit wins.
    always_comb begin
        any = 1'b0;
        sel = '0;
        idx = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (req[idx]) begin
                any = 1'b1;
                sel = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/pio_out_arbiter.sv
// rtl/pio_out_arbiter.sv - round-robin arbitrated masked writes into one shared PIO output register
module pio_out_arbiter
    import pio_arb_pkg::*;
#(
    parameter int               NUM_REQ     = 4,
    parameter int               WIDTH       = 8,
    parameter int               HOLD_CYCLES = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                            clk,
    input  logic                            reset_n,
    pio_out_arbiter_if.slave                bus,
    output logic [WIDTH-1:0]                out,
    output logic [idx_width(NUM_REQ)-1:0]   owner,
    output logic                            upd,
    output logic                            busy
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);

    state_t             state;
    state_t             state_next;
    logic               pick_any;
    logic [IDX_W-1:0]   pick_sel;
    logic [NUM_REQ-1:0] gnt_q;
    logic [WIDTH-1:0]   pdata;
    logic [WIDTH-1:0]   pmask;
    logic [WIDTH-1:0]   out_next;
    logic [HOLD_W-1:0]  hold_cnt;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req  (bus.req),
        .last (owner),
        .any  (pick_any),
        .sel  (pick_sel)
    );

    assign out_next = (out & ~pmask) | (pdata & pmask);
    assign bus.gnt  = gnt_q;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (HOLD_CYCLES == 0) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt == '0) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Requester data is captured at the decision edge, so later req/wdata changes cannot alter the write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out      <= RESET_VALUE;
            gnt_q    <= '0;
            upd      <= 1'b0;
            owner    <= IDX_W'(NUM_REQ - 1);
            pdata    <= '0;
            pmask    <= '0;
            hold_cnt <= '0;
        end else begin
            gnt_q <= '0;
            upd   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        gnt_q <= NUM_REQ'(1) << pick_sel;
                        owner <= pick_sel;
                        pdata <= bus.wdata[pick_sel*WIDTH +: WIDTH];
                        pmask <= bus.wmask[pick_sel*WIDTH +: WIDTH];
                    end
                end
                ST_GRANT: begin
                    out      <= out_next;
                    upd      <= (out_next != out);
                    hold_cnt <= HOLD_LOAD;
                end
                ST_HOLD: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pio_out_arbiter.sv
// tb/tb_pio_out_arbiter.sv - randomized and directed bench for pio_out_arbiter against a cycle-level model
module tb_pio_out_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset_n;
    always #10 clk = ~clk;

    pio_out_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus_a ();
    pio_out_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus_b ();

    logic [N-1:0]   req_v   [2];
    logic [N*W-1:0] wdata_v [2];
    logic [N*W-1:0] wmask_v [2];
    logic [N-1:0]   gnt_o   [2];
    logic [1:0][W-1:0] out_o;
    logic [1:0][1:0]   owner_o;
    logic [1:0]        upd_o;
    logic [1:0]        busy_o;

    assign bus_a.req   = req_v[0];
    assign bus_a.wdata = wdata_v[0];
    assign bus_a.wmask = wmask_v[0];
    assign bus_b.req   = req_v[1];
    assign bus_b.wdata = wdata_v[1];
    assign bus_b.wmask = wmask_v[1];
    assign gnt_o[0]    = bus_a.gnt;
    assign gnt_o[1]    = bus_b.gnt;

    pio_out_arbiter #(.NUM_REQ(N), .WIDTH(W), .HOLD_CYCLES(0), .RESET_VALUE(8'h00)) u_dut_h0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a),
        .out     (out_o[0]),
        .owner   (owner_o[0]),
        .upd     (upd_o[0]),
        .busy    (busy_o[0])
    );

    pio_out_arbiter #(.NUM_REQ(N), .WIDTH(W), .HOLD_CYCLES(3), .RESET_VALUE(8'h00)) u_dut_h3 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b),
        .out     (out_o[1]),
        .owner   (owner_o[1]),
        .upd     (upd_o[1]),
        .busy    (busy_o[1])
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: an arbiter is free when no busy cycles remain; a grant costs 1+HOLD busy cycles.
    logic [W-1:0] m_out   [2];
    logic [W-1:0] m_pdata [2];
    logic [W-1:0] m_pmask [2];
    int           m_owner [2];
    int           m_left  [2];
    bit           m_pend  [2];
    logic [N-1:0] exp_gnt [2];
    bit           exp_upd [2];
    int           gnt_hits [2][N];
    int           upd_hits [2];
    int           rearm    [2][N];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int hold_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic int oh_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_out[k]   = 8'h00;
            m_owner[k] = N - 1;
            m_left[k]  = 0;
            m_pend[k]  = 0;
            exp_gnt[k] = '0;
            exp_upd[k] = 0;
        end
    endtask

    task automatic model_edge(input int k);
        logic [W-1:0] nv;
        int pick;
        bit found;
        exp_gnt[k] = '0;
        exp_upd[k] = 0;
        if (m_left[k] > 0) begin
            if (m_pend[k]) begin
                nv = (m_out[k] & ~m_pmask[k]) | (m_pdata[k] & m_pmask[k]);
                exp_upd[k] = (nv != m_out[k]);
                m_out[k]   = nv;
                m_pend[k]  = 0;
            end
            m_left[k]--;
        end else if (req_v[k] != '0) begin
            found = 0;
            pick  = 0;
            for (int s = 1; s <= N; s++) begin
                if (!found && req_v[k][(m_owner[k] + s) % N]) begin
                    found = 1;
                    pick  = (m_owner[k] + s) % N;
                end
            end
            exp_gnt[k] = N'(1) << pick;
            m_owner[k] = pick;
            m_pdata[k] = wdata_v[k][pick*W +: W];
            m_pmask[k] = wmask_v[k][pick*W +: W];
            m_pend[k]  = 1;
            m_left[k]  = 1 + hold_of(k);
        end
    endtask

    task automatic cycle();
        for (int k = 0; k < 2; k++) model_edge(k);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("gnt[%0d]", k),   32'(gnt_o[k]),   32'(exp_gnt[k]));
            check_eq($sformatf("out[%0d]", k),   32'(out_o[k]),   32'(m_out[k]));
            check_eq($sformatf("owner[%0d]", k), 32'(owner_o[k]), 32'(m_owner[k]));
            check_eq($sformatf("upd[%0d]", k),   32'(upd_o[k]),   32'(exp_upd[k]));
            check_eq($sformatf("busy[%0d]", k),  32'(busy_o[k]),  32'(m_left[k] > 0));
            for (int i = 0; i < N; i++) if (gnt_o[k][i]) gnt_hits[k][i]++;
            if (upd_o[k]) upd_hits[k]++;
        end
    endtask

    task automatic set_req(input int k, input int i, input logic [W-1:0] d, input logic [W-1:0] m);
        req_v[k][i]             = 1'b1;
        wdata_v[k][i*W +: W]    = d;
        wmask_v[k][i*W +: W]    = m;
    endtask

    task automatic drop_granted();
        for (int k = 0; k < 2; k++) req_v[k] = req_v[k] & ~gnt_o[k];
    endtask

    task automatic run_quiet(input int maxc);
        int c = 0;
        while (((req_v[0] | req_v[1]) != '0 || busy_o != 2'b00) && c < maxc) begin
            cycle();
            drop_granted();
            c++;
        end
        if (c >= maxc) check_eq("quiet_timeout", 32'(c), 32'(0));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) req_v[k] = '0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("rst_out[%0d]", k),   32'(out_o[k]),   32'h00);
            check_eq($sformatf("rst_gnt[%0d]", k),   32'(gnt_o[k]),   32'h0);
            check_eq($sformatf("rst_owner[%0d]", k), 32'(owner_o[k]), 32'd3);
            check_eq($sformatf("rst_busy[%0d]", k),  32'(busy_o[k]),  32'd0);
            check_eq($sformatf("rst_upd[%0d]", k),   32'(upd_o[k]),   32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int u0, g0, g2, fair_next, last_g1, idx, r;
        logic [W-1:0] d, m;
        for (int k = 0; k < 2; k++) begin
            req_v[k] = '0; wdata_v[k] = '0; wmask_v[k] = '0; upd_hits[k] = 0;
            for (int i = 0; i < N; i++) begin gnt_hits[k][i] = 0; rearm[k][i] = 0; end
        end
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();
        repeat (3) cycle();

        // Single write, then masked merge
        for (int k = 0; k < 2; k++) set_req(k, 0, 8'hA5, 8'hFF);
        cycle();
        check_eq("sw_gnt", 32'(gnt_o[0]), 32'h1);
        check_eq("sw_busy_n1", 32'(busy_o[0]), 32'd1);
        check_eq("sw_out_n1", 32'(out_o[0]), 32'h00);
        drop_granted();
        cycle();
        check_eq("sw_out_n2", 32'(out_o[0]), 32'hA5);
        check_eq("sw_upd_n2", 32'(upd_o[0]), 32'd1);
        check_eq("sw_busy_n2", 32'(busy_o[0]), 32'd0);
        run_quiet(50);

        for (int k = 0; k < 2; k++) set_req(k, 1, 8'h0F, 8'h0F);
        run_quiet(50);
        check_eq("merge_out0", 32'(out_o[0]), 32'hAF);
        check_eq("merge_out1", 32'(out_o[1]), 32'hAF);

        u0 = upd_hits[0]; g0 = gnt_hits[0][1];
        for (int k = 0; k < 2; k++) set_req(k, 1, 8'h0F, 8'h0F);
        run_quiet(50);
        check_eq("repeat_gnt", 32'(gnt_hits[0][1] - g0), 32'd1);
        check_eq("repeat_upd", 32'(upd_hits[0] - u0), 32'd0);

        u0 = upd_hits[0];
        for (int k = 0; k < 2; k++) set_req(k, 2, 8'hFF, 8'h00);
        run_quiet(50);
        check_eq("mask0_out", 32'(out_o[0]), 32'hAF);
        check_eq("mask0_upd", 32'(upd_hits[0] - u0), 32'd0);

        // Fairness with all four requesting; last winner was requester 2
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++) set_req(k, i, W'($urandom), W'($urandom));
        fair_next = 3;
        last_g1 = -1;
        repeat (60) begin
            cycle();
            if (gnt_o[0] != '0) begin
                idx = oh_idx(gnt_o[0]);
                check_eq("rr_order", 32'(idx), 32'(fair_next));
                fair_next = (fair_next + 1) % N;
            end
            if (gnt_o[1] != '0) begin
                if (last_g1 >= 0) check_eq("hold_gap", 32'(cyc - last_g1), 32'd5);
                last_g1 = cyc;
            end
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < N; i++) begin
                    if (gnt_o[k][i]) begin
                        req_v[k][i] = 1'b0;
                        rearm[k][i] = 2;
                    end else if (rearm[k][i] > 0) begin
                        rearm[k][i]--;
                        if (rearm[k][i] == 0) set_req(k, i, W'($urandom), W'($urandom));
                    end
                end
        end
        for (int k = 0; k < 2; k++) req_v[k] = '0;
        run_quiet(50);

        // Withdraw inside the HOLD window of the HOLD_CYCLES=3 instance
        for (int k = 0; k < 2; k++) set_req(k, 0, 8'h3C, 8'hFF);
        cycle();
        drop_granted();
        cycle();
        g2 = gnt_hits[1][2];
        set_req(1, 2, 8'hC3, 8'hFF);
        cycle();
        req_v[1][2] = 1'b0;
        run_quiet(50);
        check_eq("withdraw_gnt2", 32'(gnt_hits[1][2] - g2), 32'd0);

        // Random traffic
        repeat (400) begin
            cycle();
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < N; i++) begin
                    if (gnt_o[k][i]) begin
                        if ($urandom_range(9) != 0) req_v[k][i] = 1'b0;
                    end else if (!req_v[k][i]) begin
                        if ($urandom_range(3) == 0) begin
                            r = $urandom_range(3);
                            d = W'($urandom);
                            m = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : W'($urandom);
                            set_req(k, i, d, m);
                        end
                    end else if ($urandom_range(19) == 0) begin
                        req_v[k][i] = 1'b0;
                    end
                end
        end
        for (int k = 0; k < 2; k++) req_v[k] = '0;
        run_quiet(50);

        // Reset while a 0xFF write is pending in GRANT
        for (int k = 0; k < 2; k++) set_req(k, 3, 8'hFF, 8'hFF);
        cycle();
        check_eq("pre_rst_gnt0", 32'(gnt_o[0] != '0), 32'd1);
        check_eq("pre_rst_gnt1", 32'(gnt_o[1] != '0), 32'd1);
        do_reset();
        repeat (4) cycle();
        check_eq("post_rst_out0", 32'(out_o[0]), 32'h00);
        check_eq("post_rst_out1", 32'(out_o[1]), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pio_out_arbiter.md
Name: pio_out_arbiter

Overview:
- Shares one WIDTH-bit output register (the LED/GPIO PIO export bus) among NUM_REQ requesters, e.g. HPS PIO mirror, FPGA user logic and debug.
- Each requester issues a masked write under a req/gnt handshake. A round-robin arbiter picks one per cycle.
- An optional hold window enforces minimum spacing between committed writes.
- Sits between the soc_system PIO exports and the board LED/GPIO pins.

Parameters:
- NUM_REQ, 4, number of requesters (1..16).
- WIDTH, 8, output register width.
- HOLD_CYCLES, 0, idle cycles forced after each commit (0..65535).
- RESET_VALUE, 0, value of out after reset.

Ports:
- clk  input  1  single clock, 50 MHz domain.
- reset_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester write request, level.
- wdata  input  NUM_REQ*WIDTH  requester i data at [i*WIDTH +: WIDTH].
- wmask  input  NUM_REQ*WIDTH  requester i bit-enable, same packing.
- gnt  output  NUM_REQ  one-hot, one-cycle grant pulse, registered.
- out  output  WIDTH  shared output register.
- owner  output  clog2(NUM_REQ) (min 1)  index of last granted requester.
- upd  output  1  one-cycle pulse when out changes value.
- busy  output  1  high in GRANT and HOLD states.

Behaviour:
- Reset (async, reset_n=0): out=RESET_VALUE, gnt=0, upd=0, busy=0, owner=NUM_REQ-1, so requester 0 has top priority first, state=IDLE, hold counter=0.
- States: IDLE, GRANT, HOLD.
- IDLE, no req: stay in IDLE.
- IDLE, any req: choose the first set req bit searching from owner+1 upward with wrap (NUM_REQ-1 -> 0). At the clock edge:
  - latch sel, wdata[sel] and wmask[sel] into pending regs;
  - gnt <= onehot(sel), owner <= sel, state <= GRANT.
- GRANT (one cycle): gnt is high for exactly this cycle. At the edge:
  - out <= (out & ~pmask) | (pdata & pmask);
  - upd <= (new out != old out);
  - gnt <= 0;
  - if HOLD_CYCLES==0, state <= IDLE; otherwise state <= HOLD with counter = HOLD_CYCLES-1.
- HOLD: counter decrements each cycle. When counter==0, state <= IDLE. req is ignored but not lost; requesters keep req high until they see gnt.
- Latency: req seen in IDLE cycle N -> gnt high in cycle N+1 -> new out visible from cycle N+2. upd is high in cycle N+2.
- Throughput: one commit per 2+HOLD_CYCLES cycles.
- Requester rules:
  - wdata/wmask are sampled only at the IDLE decision edge.
  - Dropping req after that edge does not cancel the write.
  - Dropping req before it is a clean withdraw.
  - A requester must deassert req in its gnt cycle, or be treated as a new request.
- Boundaries:
  - wmask all-zero: grant still issued, out unchanged, upd=0.
  - Data equal to the current out: upd=0.
  - NUM_REQ=1: owner is constant 0; the arbiter degenerates to a grant every 2+HOLD_CYCLES cycles.
  - Simultaneous reqs: exactly one gnt bit is ever set.
  - Reset mid-GRANT or mid-HOLD: immediate return to reset values; the pending write is discarded.

Decomposition:
- Shared package pio_arb_pkg holds:
  - state encoding (IDLE=0, GRANT=1, HOLD=2);
  - function for index width (clog2 with minimum 1);
  - hold counter width constant (16).
- One natural sub-module: rr_pick, a combinational round-robin selector.
  - Inputs: req vector, last index.
  - Outputs: any, sel.
- Top holds the FSM, pending regs, out register and hold counter.

Test Plan:
- Reset check: reset_n=0 mid-operation, then release -> out=0x00, gnt=0, owner=3, busy=0, no gnt until req rises.
- Single write (HOLD_CYCLES=0): req=0001, wdata0=0xA5, wmask0=0xFF in cycle N -> gnt=0001 in N+1; out=0xA5 and upd=1 in N+2; busy high only in N+1.
- Masked merge: out=0xA5, then req1 with wdata=0x0F, wmask=0x0F -> out=0xAF. Repeat the same write -> gnt issued, upd=0.
- Round-robin fairness: req=1111 held, each requester drops req on its gnt and re-raises 2 cycles later -> grant order 0,1,2,3,0,... and no requester granted twice before all others.
- Hold spacing (HOLD_CYCLES=3): req0 and req2 held -> gnt pulses exactly 5 cycles apart; busy high 4 of every 5 cycles.
- Withdraw and async reset: req2 raised and dropped in the same HOLD window -> no gnt to 2. Separately, reset_n pulsed low during GRANT with pending 0xFF -> out stays RESET_VALUE.
